// File: rtl/pong_frame_ctrl_if.sv
`default_nettype none
// pong_frame_ctrl_if: groups the frame tick, paddle pixel stream, sequencer state
// and VGA plot bus around the Pong frame controller.
interface pong_frame_ctrl_if;
   logic       frame_tick;
   logic [7:0] pad_x;
   logic [6:0] pad_y;
   logic [2:0] state;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       plot;
   logic       frame_done;

   modport master (
      input  frame_tick, pad_x, pad_y,
      output state, vga_x, vga_y, colour, plot, frame_done
   );

   modport slave (
      output frame_tick, pad_x, pad_y,
      input  state, vga_x, vga_y, colour, plot, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/pong_frame_ctrl.sv
`default_nettype none
// pong_frame_ctrl: Pong drawing sequencer. Clears the screen once, then runs paddle
// draw and erase passes on alternate frame ticks, muxing pixels onto the VGA plot bus.
module pong_frame_ctrl #(
   parameter int         SCREEN_W           = 160,
   parameter int         SCREEN_H           = 120,
   parameter int         BORDER_Y           = 30,
   parameter int         PADDLE_PASS_CYCLES = 43,
   parameter logic [2:0] FG_COLOUR          = 3'b111,
   parameter logic [2:0] BG_COLOUR          = 3'b000
) (
   input  logic              clk,
   input  logic              resetn,
   pong_frame_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_CLEAR  = 3'd1,
      S_RUN    = 3'd2,
      S_PADDLE = 3'd4,
      S_HOLD   = 3'd5
   } state_t;

   localparam logic [7:0] X_LAST    = 8'(SCREEN_W - 1);
   localparam logic [6:0] Y_LAST    = 7'(SCREEN_H - 1);
   localparam logic [6:0] Y_BORDER  = 7'(BORDER_Y);
   localparam logic [5:0] PASS_LAST = 6'(PADDLE_PASS_CYCLES - 1);

   // Raw bits rather than the enum type so the unused codes 3/6/7 stay representable.
   logic [2:0] state_q;
   logic [7:0] x_q;
   logic [6:0] y_q;
   logic [5:0] pass_q;
   logic       draw_q;
   logic       frame_done_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_INIT;
         x_q          <= 8'd0;
         y_q          <= 7'd0;
         pass_q       <= 6'd0;
         draw_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_INIT: begin
               state_q <= S_CLEAR;
               x_q     <= 8'd0;
               y_q     <= 7'd0;
            end
            S_CLEAR: begin
               if (x_q == X_LAST) begin
                  x_q <= 8'd0;
                  if (y_q == Y_LAST) begin
                     y_q     <= 7'd0;
                     state_q <= S_RUN;
                  end else begin
                     y_q <= y_q + 7'd1;
                  end
               end else begin
                  x_q <= x_q + 8'd1;
               end
            end
            S_RUN: begin
               if (bus.frame_tick) begin
                  state_q <= S_PADDLE;
                  draw_q  <= 1'b1;
                  pass_q  <= 6'd0;
               end
            end
            S_PADDLE: begin
               if (pass_q == PASS_LAST) begin
                  pass_q <= 6'd0;
                  if (draw_q) begin
                     state_q      <= S_HOLD;
                     frame_done_q <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end else begin
                  pass_q <= pass_q + 6'd1;
               end
            end
            S_HOLD: begin
               if (bus.frame_tick) begin
                  state_q <= S_PADDLE;
                  draw_q  <= 1'b0;
                  pass_q  <= 6'd0;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

   logic       plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;

   // Pass cycle 0 is skipped because the paddle block needs a cycle to fill its pipeline.
   always_comb begin
      plot   = 1'b0;
      vga_x  = 8'd0;
      vga_y  = 7'd0;
      colour = BG_COLOUR;
      case (state_q)
         S_CLEAR: begin
            plot   = 1'b1;
            vga_x  = x_q;
            vga_y  = y_q;
            colour = (y_q == Y_BORDER) ? FG_COLOUR : BG_COLOUR;
         end
         S_PADDLE: begin
            colour = draw_q ? FG_COLOUR : BG_COLOUR;
            if (pass_q != 6'd0) begin
               plot  = 1'b1;
               vga_x = bus.pad_x;
               vga_y = bus.pad_y;
            end
         end
         default: ;
      endcase
   end

   assign bus.state      = state_q;
   assign bus.plot       = plot;
   assign bus.vga_x      = vga_x;
   assign bus.vga_y      = vga_y;
   assign bus.colour     = colour;
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_frame_ctrl.sv
`default_nettype none
// tb_pong_frame_ctrl: directed sequence with randomized paddle pixels, checked against
// a raster/pass model derived from screen geometry and pass rules.
module tb_pong_frame_ctrl;

   localparam int W      = 160;
   localparam int H      = 120;
   localparam int BORDER = 30;
   localparam int PASS   = 43;

   logic clk = 1'b0;
   logic resetn;
   int   errors = 0;
   int   checks = 0;

   pong_frame_ctrl_if bus();

   pong_frame_ctrl dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, 32'(bus.state), 0);
      chk({tag, "_plot"}, 32'(bus.plot), 0);
      chk({tag, "_vga_x"}, 32'(bus.vga_x), 0);
      chk({tag, "_vga_y"}, 32'(bus.vga_y), 0);
      chk({tag, "_colour"}, 32'(bus.colour), 0);
      chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
   endtask

   task automatic idle(input int n, input int exp_state);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
         chk("idle_state", 32'(bus.state), 32'(exp_state));
         chk("idle_plot", 32'(bus.plot), 0);
      end
   endtask

   // Entered at a point where the controller sits in INIT; expects one INIT cycle then
   // a full raster of W*H pixels, x fastest, border row in foreground, then RUN.
   task automatic run_clear(input int tick_at);
      int ex, ey;
      chk("clear_pre_init", 32'(bus.state), 0);
      for (int k = 0; k < W * H; k++) begin
         @(negedge clk); #1;
         if (k == tick_at + 1) bus.frame_tick = 1'b0;
         ex = k % W;
         ey = k / W;
         chk("clear_state", 32'(bus.state), 1);
         chk("clear_plot", 32'(bus.plot), 1);
         chk("clear_x", 32'(bus.vga_x), 32'(ex));
         chk("clear_y", 32'(bus.vga_y), 32'(ey));
         chk("clear_colour", 32'(bus.colour), (ey == BORDER) ? 7 : 0);
         chk("clear_fdone", 32'(bus.frame_done), 0);
         if (k == tick_at) bus.frame_tick = 1'b1;
      end
      @(negedge clk); #1;
      bus.frame_tick = 1'b0;
      chk("clear_end_state", 32'(bus.state), 2);
      chk("clear_end_plot", 32'(bus.plot), 0);
   endtask

   // Entered from RUN (draw) or HOLD (erase); launches a pass with a tick.
   task automatic run_pass(input bit draw, input int tick_at, input int rst_at,
                           output bit was_reset);
      logic [7:0] px;
      logic [6:0] py;
      was_reset = 1'b0;
      bus.frame_tick = 1'b1;
      for (int c = 0; c < PASS; c++) begin
         @(negedge clk);
         px = 8'($urandom_range(0, W - 1));
         py = 7'($urandom_range(0, H - 1));
         bus.pad_x = px;
         bus.pad_y = py;
         #1;
         if (c == 0 || c == tick_at + 1) bus.frame_tick = 1'b0;
         chk("pass_state", 32'(bus.state), 4);
         chk("pass_plot", 32'(bus.plot), (c != 0) ? 1 : 0);
         chk("pass_colour", 32'(bus.colour), draw ? 7 : 0);
         chk("pass_fdone", 32'(bus.frame_done), 0);
         if (c != 0) begin
            chk("pass_x", 32'(bus.vga_x), 32'(px));
            chk("pass_y", 32'(bus.vga_y), 32'(py));
         end
         if (c == tick_at) bus.frame_tick = 1'b1;
         if (c == rst_at) begin
            #1 resetn = 1'b0;
            bus.frame_tick = 1'b0;
            #1;
            chk_reset("async_rst");
            was_reset = 1'b1;
            return;
         end
      end
      @(negedge clk); #1;
      bus.frame_tick = 1'b0;
      if (draw) begin
         chk("draw_end_state", 32'(bus.state), 5);
         chk("draw_end_fdone", 32'(bus.frame_done), 1);
         chk("draw_end_plot", 32'(bus.plot), 0);
         @(negedge clk); #1;
         chk("hold_state", 32'(bus.state), 5);
         chk("hold_fdone_single", 32'(bus.frame_done), 0);
      end else begin
         chk("erase_end_state", 32'(bus.state), 2);
         chk("erase_end_fdone", 32'(bus.frame_done), 0);
         chk("erase_end_plot", 32'(bus.plot), 0);
      end
   endtask

   initial begin
      bit r;
      resetn         = 1'b0;
      bus.frame_tick = 1'b0;
      bus.pad_x      = 8'd0;
      bus.pad_y      = 7'd0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset("reset");

      resetn = 1'b1;
      run_clear(-1);
      idle(3, 2);

      run_pass(1'b1, -1, -1, r);
      idle(3, 5);
      run_pass(1'b0, -1, -1, r);
      idle(2, 2);

      run_pass(1'b1, 20, -1, r);
      run_pass(1'b0, 20, -1, r);
      idle(1, 2);

      run_pass(1'b1, PASS - 1, -1, r);
      idle(2, 5);
      run_pass(1'b0, PASS - 1, -1, r);
      idle(2, 2);

      run_pass(1'b1, -1, 17, r);
      chk("reset_taken", 32'(r), 1);
      @(negedge clk); #1;
      chk_reset("reset_held");
      resetn = 1'b1;
      run_clear(5000);
      idle(2, 2);

      force dut.state_q = 3'd6;
      #1;
      chk("forced_state", 32'(bus.state), 6);
      release dut.state_q;
      @(negedge clk); #1;
      chk("illegal_recover", 32'(bus.state), 0);
      run_clear(W * H - 1);
      idle(3, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
